// File: rtl/msrv_32_reg_file_wb_unit.sv
// Integer register file at the end of the writeback path.
// Two combinational read ports with same-cycle write-through bypass, plus a
// load scoreboard that flags decode-stage hazards on registers awaiting load data.
module msrv_32_reg_file_wb_unit #(
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      NREGS     = 32,
    parameter logic [XLEN-1:0]  RESET_VAL = '0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     wr_en_in,
    input  logic [$clog2(NREGS)-1:0] rd_addr_in,
    input  logic [XLEN-1:0]          rd_data_in,
    input  logic                     flush_in,
    input  logic [$clog2(NREGS)-1:0] rs1_addr_in,
    input  logic [$clog2(NREGS)-1:0] rs2_addr_in,
    output logic [XLEN-1:0]          rs1_data_out,
    output logic [XLEN-1:0]          rs2_data_out,
    input  logic                     ld_issue_in,
    input  logic [$clog2(NREGS)-1:0] ld_rd_in,
    input  logic                     ld_done_in,
    output logic                     hazard_out,
    output logic [NREGS-1:0]         busy_vec_out
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    logic wr_fire;
    logic ld_fire;
    logic clear_rs1, clear_rs2;

    // A write is live only out of reset and when not flushed; this gates both
    // the array update and the bypass so reset never exposes in-flight data.
    assign wr_fire = wr_en_in & ~flush_in & rst_in;
    assign ld_fire = ld_issue_in & ~flush_in;

    // Register array: x0 is never written, so it keeps RESET_VAL but reads as 0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (wr_fire && rd_addr_in != '0) begin
            regs_q[rd_addr_in] <= rd_data_in;
        end
    end

    // Scoreboard next state: a new load to rd wins over its previous load's writeback.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (wr_fire && ld_done_in && rd_addr_in == AW'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (ld_fire && ld_rd_in == AW'(i) && i != 0) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports: x0 forced to zero, otherwise bypass a matching write.
    always_comb begin
        rs1_data_out = regs_q[rs1_addr_in];
        rs2_data_out = regs_q[rs2_addr_in];
        if (wr_fire && rd_addr_in == rs1_addr_in) begin
            rs1_data_out = rd_data_in;
        end
        if (wr_fire && rd_addr_in == rs2_addr_in) begin
            rs2_data_out = rd_data_in;
        end
        if (rs1_addr_in == '0) begin
            rs1_data_out = '0;
        end
        if (rs2_addr_in == '0) begin
            rs2_data_out = '0;
        end
    end

    // Hazard: a register whose load writes back this cycle is served by the bypass.
    always_comb begin
        clear_rs1  = wr_fire & ld_done_in & (rd_addr_in == rs1_addr_in);
        clear_rs2  = wr_fire & ld_done_in & (rd_addr_in == rs2_addr_in);
        hazard_out = (busy_q[rs1_addr_in] & (rs1_addr_in != '0) & ~clear_rs1) |
                     (busy_q[rs2_addr_in] & (rs2_addr_in != '0) & ~clear_rs2);
    end

    assign busy_vec_out = busy_q;

endmodule

// File: tb/tb_msrv_32_reg_file_wb_unit.sv
// Bench for msrv_32_reg_file_wb_unit: directed scenarios followed by random
// traffic, all checked against an array/bit-vector reference model.
module tb_msrv_32_reg_file_wb_unit;

    logic        clk_in;
    logic        rst_in;
    logic        wr_en_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] rd_data_in;
    logic        flush_in;
    logic [4:0]  rs1_addr_in;
    logic [4:0]  rs2_addr_in;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;
    logic        ld_issue_in;
    logic [4:0]  ld_rd_in;
    logic        ld_done_in;
    logic        hazard_out;
    logic [31:0] busy_vec_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ref_regs [32];
    logic [31:0] ref_busy;

    msrv_32_reg_file_wb_unit dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .wr_en_in    (wr_en_in),
        .rd_addr_in  (rd_addr_in),
        .rd_data_in  (rd_data_in),
        .flush_in    (flush_in),
        .rs1_addr_in (rs1_addr_in),
        .rs2_addr_in (rs2_addr_in),
        .rs1_data_out(rs1_data_out),
        .rs2_data_out(rs2_data_out),
        .ld_issue_in (ld_issue_in),
        .ld_rd_in    (ld_rd_in),
        .ld_done_in  (ld_done_in),
        .hazard_out  (hazard_out),
        .busy_vec_out(busy_vec_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        ref_busy = 32'h0;
    endtask

    // Expected read: x0 is zero, a live write to the same register is seen now,
    // anything else comes from the stored contents.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic we,
                                             input logic fl, input logic [4:0] rd,
                                             input logic [31:0] d);
        if (a == 0) return 32'h0;
        if (we && !fl && rd == a) return d;
        return ref_regs[a];
    endfunction

    function automatic logic exp_pending(input logic [4:0] a, input logic we, input logic fl,
                                         input logic [4:0] rd, input logic ld);
        if (a == 0) return 1'b0;
        if (we && !fl && ld && rd == a) return 1'b0;
        return ref_busy[a];
    endfunction

    // One cycle: drive, check combinational outputs mid-cycle, clock, update
    // the model, then check the scoreboard after the edge.
    task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic fl, input logic [4:0] a1, input logic [4:0] a2,
                        input logic li, input logic [4:0] lrd, input logic ld);
        logic exp_haz;
        wr_en_in = we; rd_addr_in = rd; rd_data_in = d; flush_in = fl;
        rs1_addr_in = a1; rs2_addr_in = a2;
        ld_issue_in = li; ld_rd_in = lrd; ld_done_in = ld;
        #2;
        chk("rs1_data", rs1_data_out, exp_read(a1, we, fl, rd, d));
        chk("rs2_data", rs2_data_out, exp_read(a2, we, fl, rd, d));
        exp_haz = exp_pending(a1, we, fl, rd, ld) | exp_pending(a2, we, fl, rd, ld);
        chk("hazard", {31'h0, hazard_out}, {31'h0, exp_haz});
        @(posedge clk_in);
        if (we && !fl && rd != 0) ref_regs[rd] = d;
        if (we && !fl && ld) ref_busy[rd] = 1'b0;
        if (li && !fl && lrd != 0) ref_busy[lrd] = 1'b1;
        #1;
        chk("busy_vec", busy_vec_out, ref_busy);
    endtask

    task automatic idle_inputs();
        wr_en_in = 0; rd_addr_in = 0; rd_data_in = 0; flush_in = 0;
        rs1_addr_in = 0; rs2_addr_in = 0; ld_issue_in = 0; ld_rd_in = 0; ld_done_in = 0;
    endtask

    // Async reset mid-cycle with a write pending across the edge; the write is lost.
    task automatic mid_reset();
        idle_inputs();
        rs1_addr_in = 5'd5; rs2_addr_in = 5'd31;
        #2;
        rst_in = 1'b0;
        model_reset();
        #1;
        chk("rst_rs1", rs1_data_out, 32'h0);
        chk("rst_rs2", rs2_data_out, 32'h0);
        chk("rst_busy", busy_vec_out, 32'h0);
        chk("rst_hazard", {31'h0, hazard_out}, 32'h0);
        wr_en_in = 1; rd_addr_in = 5'd20; rd_data_in = 32'h5a5a5a5a;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst_in = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        // Fill some state so the reset below has something to clear
        step(1, 5'd5, 32'h55550005, 0, 0, 0, 0, 0, 0);
        step(1, 5'd31, 32'h3131abcd, 0, 0, 0, 1, 5'd6, 0);
        mid_reset();
        step(0, 0, 0, 0, 5'd5, 5'd31, 0, 0, 0);
        step(0, 0, 0, 0, 5'd20, 5'd6, 0, 0, 0);

        // Write then read; x0 writes dropped
        step(1, 5'd7, 32'h12345678, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 5'd7, 0, 0, 0, 0);
        chk("x7_const", rs1_data_out, 32'h12345678);
        step(1, 5'd0, 32'hdeadbeef, 0, 0, 0, 0, 0, 0);
        step(1, 5'd0, 32'hdeadbeef, 0, 5'd0, 5'd0, 0, 0, 0);

        // Bypass on both ports
        step(1, 5'd9, 32'hfeedface, 0, 5'd9, 5'd9, 0, 0, 0);
        step(0, 0, 0, 0, 5'd9, 5'd9, 0, 0, 0);

        // Flush blocks write and bypass
        step(1, 5'd3, 32'h11111111, 0, 0, 0, 0, 0, 0);
        step(1, 5'd3, 32'hbabecafe, 1, 5'd3, 5'd3, 0, 0, 0);
        step(0, 0, 0, 0, 5'd3, 0, 0, 0, 0);
        chk("x3_kept", rs1_data_out, 32'h11111111);

        // Scoreboard set, hazard, writeback clear; flushed issue does not set
        step(0, 0, 0, 0, 0, 0, 1, 5'd12, 0);
        step(0, 0, 0, 0, 5'd12, 0, 1, 5'd13, 0);
        chk("busy12", {31'h0, busy_vec_out[12]}, 32'h1);
        step(1, 5'd12, 32'habcdef01, 0, 5'd12, 0, 0, 0, 1);
        chk("busy12_clr", {31'h0, busy_vec_out[12]}, 32'h0);
        step(0, 0, 0, 1, 0, 5'd13, 1, 5'd14, 0);
        step(1, 5'd13, 32'h0000abcd, 0, 0, 5'd13, 0, 0, 0);
        step(1, 5'd13, 32'h0000abce, 0, 5'd13, 5'd14, 0, 0, 1);

        // Set/clear collision keeps busy; load to x0 leaves scoreboard alone
        step(0, 0, 0, 0, 0, 0, 1, 5'd4, 0);
        step(1, 5'd4, 32'h44444444, 0, 5'd4, 0, 1, 5'd4, 1);
        chk("busy4_kept", {31'h0, busy_vec_out[4]}, 32'h1);
        step(0, 0, 0, 0, 5'd4, 5'd4, 1, 5'd0, 0);

        // Random traffic, addresses biased to a small range for frequent collisions
        for (int n = 0; n < 600; n++) begin
            logic [4:0] rd, a1, a2, lrd;
            logic we, fl, li, ld;
            rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            a1  = 5'($urandom_range(0, 7));
            a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            lrd = 5'($urandom_range(0, 7));
            we  = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 7) == 0);
            li  = ($urandom_range(0, 2) == 0);
            ld  = ($urandom_range(0, 1) == 0);
            step(we, rd, $urandom, fl, a1, a2, li, lrd, ld);
            if (n == 300) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
